dcache_port_arb: RTL and testbench
==================================

# dcache_port_arb

N-port arbiter, SRAM multiplexer and registered tag comparator for the L1 data cache arrays. It sits between the cache controllers and miss handler on one side and the per-way data/tag/valid-dirty SRAMs on the other. It generalises the fixed 4-port, fixed-priority tag compare to any port count and way count. It adds per-port response tagging, multi-cycle grant locking for refill/writeback sequences, and multi-hit detection.

## Interface
- NR_PORTS, 4: number of requesters; port 0 is the miss handler.
- NR_WAYS, 8: set associativity.
- INDEX_WIDTH, 12: array index width (byte address within way).
- TAG_WIDTH, 44: tag width.
- LINE_WIDTH, 128: data line width, bits; multiple of 8.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_i  in  NR_PORTS×NR_WAYS  per-port way-select mask; nonzero means request.
- lock_i  in  NR_PORTS  hold grant on the following cycles.
- addr_i  in  NR_PORTS×INDEX_WIDTH  index.
- tag_i  in  NR_PORTS×TAG_WIDTH  lookup tag, sampled on grant.
- we_i  in  NR_PORTS  write.
- wdata_i  in  NR_PORTS×(LINE_WIDTH+TAG_WIDTH+2)  {valid, dirty, tag, data}.
- be_i  in  NR_PORTS×(LINE_WIDTH/8+TAG_WIDTH/8+1)  byte enables {vldrty, tag, data}.
- gnt_o  out  NR_PORTS  one-hot grant, combinational.
- rvalid_o  out  NR_PORTS  one-hot read response strobe.
- hit_way_o  out  NR_WAYS  ways whose tag matches and valid=1.
- multi_hit_o  out  1  more than one bit of hit_way_o set while rvalid.
- ram_req_o  out  NR_WAYS; ram_we_o  out  1; ram_addr_o  out  INDEX_WIDTH; ram_wdata_o, ram_be_o  out  as granted port.
- ram_rdata_i  in  NR_WAYS×(LINE_WIDTH+TAG_WIDTH+2)  per-way read data, one cycle after ram_req_o.
- rdata_o  out  NR_WAYS×(LINE_WIDTH+TAG_WIDTH+2)  passthrough of ram_rdata_i.

## Operation
- Request: port p requests when |req_i[p]. At most one gnt_o bit per cycle. No grant when no request.
- Lock owner: if registered owner L is valid and |req_i[L] is set, L wins over all others, including port 0.
- Otherwise the winner is chosen by the policy in Configuration.
- Lock capture: if the granted port has lock_i=1, it becomes owner for the next cycle. The lock releases the first cycle its request drops or lock_i=0 at grant.
- RAM mux: ram_req_o=req_i[g], ram_we_o=we_i[g], ram_addr_o, ram_wdata_o and ram_be_o taken from granted port g. All are zero when no grant.
- Response stage (registered): on a granted read (we_i=0), register resp_port=g, resp_tag=tag_i[g], resp_v=1. Writes produce no rvalid.
- Next cycle: rvalid_o[resp_port]=resp_v.
  - hit_way_o[w] = resp_v & ram_rdata_i[w].valid & (ram_rdata_i[w].tag==resp_tag).
  - multi_hit_o = resp_v & popcount(hit_way_o)>1.
- When resp_v=0: hit_way_o=0 and multi_hit_o=0.
- Back-to-back: a grant every cycle is legal; the response pipeline is one deep and fully overlapped.
- Reset (any cycle, including mid-lock): owner cleared, round-robin pointer to 1, resp_v=0. Outputs reset to zero: gnt_o, rvalid_o, hit_way_o, multi_hit_o, ram_*_o (with no request).

## Timing
- Grant: combinational from req_i/lock_i and registered state, same cycle.
- Read latency: rvalid_o/hit_way_o exactly 1 cycle after gnt_o. rdata_o is valid in that same cycle.
- Registered state is updated on clk_i rising edge only: owner, rr pointer, resp_port, resp_tag, resp_v.
- A requester that is not granted must hold its request; it is retried each cycle with no state lost.

## Configuration
- DCACHE_ARB_RR_EN defined: port 0 has absolute priority. Ports 1..NR_PORTS-1 are round-robin.
  - Pointer starts at 1 and advances to the granted port +1, wrapping NR_PORTS-1→1.
  - The pointer is unchanged when port 0 or the lock owner wins.
- Not defined: fixed priority, lowest index wins. No pointer register.
- Locking and response behaviour are identical in both builds.

## Test plan
- Single read: port 2 reads addr 0x040 with tag 0xABC, and way 3 returns valid=1, tag 0xABC -> gnt_o=0100; next cycle rvalid_o=0100, hit_way_o=0x08, multi_hit_o=0.
- Contention with RR_EN: ports 1, 2 and 3 request continuously -> grants 1,2,3,1 on consecutive cycles. Port 0 asserted in cycle 2 -> that cycle grants 0 and the pointer holds.
- Lock: port 0 locks for 4 cycles while ports 1–3 request -> gnt_o=0001 for all 4 cycles. lock_i drop -> next cycle goes to another port.
- Multi-hit: ways 0 and 5 both valid with a matching tag -> hit_way_o=0x21, multi_hit_o=1.
- Write: port 1 writes -> ram_we_o=1 and ram_be_o equal to be_i[1]; no rvalid the next cycle.
- Reset mid-lock: assert rst_i while port 3 owns the lock -> all outputs 0. After release, a port-1 request is granted over a port-3 request when the pointer is at 1.

Source files
------------

// File: rtl/dcache_port_arb.sv
// L1 data-cache array port arbiter: grant/lock selection, SRAM request mux and registered tag compare.
// Define DCACHE_ARB_RR_EN for port-0 priority plus round-robin among ports 1..NR_PORTS-1; default is fixed priority.
module dcache_port_arb #(
  parameter int NR_PORTS    = 4,
  parameter int NR_WAYS     = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44,
  parameter int LINE_WIDTH  = 128,
  localparam int ENTRY_W    = LINE_WIDTH + TAG_WIDTH + 2,
  localparam int BE_W       = LINE_WIDTH / 8 + TAG_WIDTH / 8 + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NR_PORTS*NR_WAYS-1:0]     req_i,
  input  logic [NR_PORTS-1:0]             lock_i,
  input  logic [NR_PORTS*INDEX_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS*TAG_WIDTH-1:0]   tag_i,
  input  logic [NR_PORTS-1:0]             we_i,
  input  logic [NR_PORTS*ENTRY_W-1:0]     wdata_i,
  input  logic [NR_PORTS*BE_W-1:0]        be_i,
  output logic [NR_PORTS-1:0]             gnt_o,
  output logic [NR_PORTS-1:0]             rvalid_o,
  output logic [NR_WAYS-1:0]              hit_way_o,
  output logic                            multi_hit_o,
  output logic [NR_WAYS-1:0]              ram_req_o,
  output logic                            ram_we_o,
  output logic [INDEX_WIDTH-1:0]          ram_addr_o,
  output logic [ENTRY_W-1:0]              ram_wdata_o,
  output logic [BE_W-1:0]                 ram_be_o,
  input  logic [NR_WAYS*ENTRY_W-1:0]      ram_rdata_i,
  output logic [NR_WAYS*ENTRY_W-1:0]      rdata_o
);

  localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  function automatic logic more_than_one(input logic [NR_WAYS-1:0] v);
    return |(v & (v - NR_WAYS'(1)));
  endfunction

  logic [NR_PORTS-1:0] req_any;
  logic                gnt_vld;
  logic [PW-1:0]       gnt_idx;
  logic                owner_vld_q, owner_vld_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic                vld_p1;
  logic [PW-1:0]       resp_port_p1;
  logic [TAG_WIDTH-1:0] resp_tag_p1;
`ifdef DCACHE_ARB_RR_EN
  logic                owner_win;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) req_any[p] = |req_i[p*NR_WAYS +: NR_WAYS];
  end

  // p0: grant selection; a live lock owner outranks every other requester
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef DCACHE_ARB_RR_EN
    owner_win = 1'b0;
`endif
    if (owner_vld_q && req_any[owner_q]) begin
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
`ifdef DCACHE_ARB_RR_EN
      owner_win = 1'b1;
`endif
    end else begin
`ifdef DCACHE_ARB_RR_EN
      if (req_any[0]) begin
        gnt_vld = 1'b1;
      end else begin
        // two passes: from the pointer upward, then wrap back to port 1
        for (int p = 1; p < NR_PORTS; p++) begin
          if (!gnt_vld && req_any[p] && p >= int'(rr_ptr_q)) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(p);
          end
        end
        for (int p = 1; p < NR_PORTS; p++) begin
          if (!gnt_vld && req_any[p]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(p);
          end
        end
      end
`else
      for (int p = 0; p < NR_PORTS; p++) begin
        if (!gnt_vld && req_any[p]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(p);
        end
      end
`endif
    end
  end

  always_comb begin
    owner_vld_d = gnt_vld & lock_i[gnt_idx];
    owner_d     = gnt_idx;
  end

`ifdef DCACHE_ARB_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld && !owner_win && gnt_idx != '0)
      rr_ptr_d = (gnt_idx == PW'(NR_PORTS - 1)) ? PW'(1) : gnt_idx + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= PW'(1);
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    gnt_o       = '0;
    ram_req_o   = '0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    if (gnt_vld) begin
      gnt_o[gnt_idx] = 1'b1;
      ram_req_o      = req_i[gnt_idx*NR_WAYS +: NR_WAYS];
      ram_we_o       = we_i[gnt_idx];
      ram_addr_o     = addr_i[gnt_idx*INDEX_WIDTH +: INDEX_WIDTH];
      ram_wdata_o    = wdata_i[gnt_idx*ENTRY_W +: ENTRY_W];
      ram_be_o       = be_i[gnt_idx*BE_W +: BE_W];
    end
  end

  // p0 -> p1: lock owner and read-response capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      vld_p1      <= 1'b0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      vld_p1      <= gnt_vld & ~we_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    resp_port_p1 <= gnt_idx;
    resp_tag_p1  <= tag_i[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
  end

  // p1: tag compare against the way read data returned this cycle
  always_comb begin
    rvalid_o  = '0;
    hit_way_o = '0;
    if (vld_p1) rvalid_o[resp_port_p1] = 1'b1;
    for (int w = 0; w < NR_WAYS; w++) begin
      hit_way_o[w] = vld_p1 & ram_rdata_i[w*ENTRY_W + ENTRY_W - 1] &
                     (ram_rdata_i[w*ENTRY_W + LINE_WIDTH +: TAG_WIDTH] == resp_tag_p1);
    end
    multi_hit_o = more_than_one(hit_way_o);
  end

  assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Self-checking bench for dcache_port_arb: directed table, hand sequences and random traffic vs a reference model.
`timescale 1ns/1ps
module tb_dcache_port_arb;
  localparam int NP = 4, NW = 8, IW = 12, TW = 44, LW = 128;
  localparam int E  = LW + TW + 2;
  localparam int BW = LW / 8 + TW / 8 + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP*NW-1:0]  req_i;
  logic [NP-1:0]     lock_i, we_i;
  logic [NP*IW-1:0]  addr_i;
  logic [NP*TW-1:0]  tag_i;
  logic [NP*E-1:0]   wdata_i;
  logic [NP*BW-1:0]  be_i;
  logic [NP-1:0]     gnt_o, rvalid_o;
  logic [NW-1:0]     hit_way_o, ram_req_o;
  logic              multi_hit_o, ram_we_o;
  logic [IW-1:0]     ram_addr_o;
  logic [E-1:0]      ram_wdata_o;
  logic [BW-1:0]     ram_be_o;
  logic [NW*E-1:0]   ram_rdata_i, rdata_o;

  always #5 clk = ~clk;

  dcache_port_arb #(.NR_PORTS(NP), .NR_WAYS(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i), .tag_i(tag_i),
    .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .hit_way_o(hit_way_o), .multi_hit_o(multi_hit_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
    .ram_rdata_i(ram_rdata_i), .rdata_o(rdata_o)
  );

  logic [NW-1:0] t_req   [NP];
  logic [NP-1:0] t_lock, t_we;
  logic [IW-1:0] t_addr  [NP];
  logic [TW-1:0] t_tag   [NP];
  logic [E-1:0]  t_wdata [NP];
  logic [BW-1:0] t_be    [NP];
  logic [E-1:0]  t_rd    [NW];

  int            m_owner = -1;
  int            m_ptr   = 1;
  bit            m_rv    = 1'b0;
  int            m_rport = 0;
  logic [TW-1:0] m_rtag  = '0;
  int            m_g     = -1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] rq, lk, wr, g_rr, v_rr, g_fx, v_fx;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [1399:0] act, input logic [1399:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < NP; p++) begin
      t_req[p] = '0; t_addr[p] = '0; t_tag[p] = '0; t_wdata[p] = '0; t_be[p] = '0;
    end
    t_lock = '0;
    t_we   = '0;
    for (int w = 0; w < NW; w++) t_rd[w] = '0;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      req_i[p*NW +: NW]  = t_req[p];
      addr_i[p*IW +: IW] = t_addr[p];
      tag_i[p*TW +: TW]  = t_tag[p];
      wdata_i[p*E +: E]  = t_wdata[p];
      be_i[p*BW +: BW]   = t_be[p];
    end
    lock_i = t_lock;
    we_i   = t_we;
    for (int w = 0; w < NW; w++) ram_rdata_i[w*E +: E] = t_rd[w];
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 1;
    m_rv    = 1'b0;
  endtask

  function automatic int model_winner();
    if (m_owner >= 0 && |t_req[m_owner]) return m_owner;
`ifdef DCACHE_ARB_RR_EN
    if (|t_req[0]) return 0;
    for (int k = 0; k < NP - 1; k++) begin
      int c;
      c = 1 + ((m_ptr - 1 + k) % (NP - 1));
      if (|t_req[c]) return c;
    end
    return -1;
`else
    for (int p = 0; p < NP; p++) if (|t_req[p]) return p;
    return -1;
`endif
  endfunction

  // Apply current inputs, let them settle, compare every output against the model.
  task automatic settle_check();
    logic [NP-1:0] e_gnt, e_rv;
    logic [NW-1:0] e_rreq, e_hit;
    logic          e_we, e_multi;
    logic [IW-1:0] e_addr;
    logic [E-1:0]  e_wd;
    logic [BW-1:0] e_be;
    logic [NW*E-1:0] e_rd;
    drive();
    #1;
    m_g = model_winner();
    e_gnt = '0; e_rreq = '0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0; e_rv = '0;
    if (m_g >= 0) begin
      e_gnt[m_g] = 1'b1;
      e_rreq = t_req[m_g];
      e_we   = t_we[m_g];
      e_addr = t_addr[m_g];
      e_wd   = t_wdata[m_g];
      e_be   = t_be[m_g];
    end
    if (m_rv) e_rv[m_rport] = 1'b1;
    for (int w = 0; w < NW; w++) begin
      e_hit[w] = m_rv && t_rd[w][E-1] && (t_rd[w][LW +: TW] == m_rtag);
      e_rd[w*E +: E] = t_rd[w];
    end
    e_multi = ($countones(e_hit) > 1);
    chk("gnt", gnt_o, e_gnt);
    chk("ram_req", ram_req_o, e_rreq);
    chk("ram_we", ram_we_o, e_we);
    chk("ram_addr", ram_addr_o, e_addr);
    chk("ram_wdata", ram_wdata_o, e_wd);
    chk("ram_be", ram_be_o, e_be);
    chk("rvalid", rvalid_o, e_rv);
    chk("hit_way", hit_way_o, e_hit);
    chk("multi_hit", multi_hit_o, e_multi);
    chk("rdata", rdata_o, e_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_g >= 0) begin
      if (m_g != 0 && m_g != m_owner) m_ptr = (m_g == NP - 1) ? 1 : m_g + 1;
      m_rv    = !t_we[m_g];
      m_rport = m_g;
      m_rtag  = t_tag[m_g];
      m_owner = t_lock[m_g] ? m_g : -1;
    end else begin
      m_rv    = 1'b0;
      m_owner = -1;
    end
    #1;
  endtask

  task automatic check_all_zero(input string tagname);
    chk({tagname, "_gnt"}, gnt_o, '0);
    chk({tagname, "_rvalid"}, rvalid_o, '0);
    chk({tagname, "_hit"}, hit_way_o, '0);
    chk({tagname, "_multi"}, multi_hit_o, '0);
    chk({tagname, "_ram_req"}, ram_req_o, '0);
    chk({tagname, "_ram_we"}, ram_we_o, '0);
    chk({tagname, "_ram_addr"}, ram_addr_o, '0);
    chk({tagname, "_ram_wdata"}, ram_wdata_o, '0);
    chk({tagname, "_ram_be"}, ram_be_o, '0);
  endtask

  initial begin
    tbl[0]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    tbl[1]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0010, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0010};
    tbl[3]  = '{4'b1110, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0001};
    tbl[4]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
    tbl[5]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    tbl[7]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    tbl[8]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    tbl[10] = '{4'b1110, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0001};
    tbl[11] = '{4'b1110, 4'b1000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0010};
    tbl[12] = '{4'b1111, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 4'b0010};
    tbl[13] = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    tbl[14] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0001, 4'b0001};
    tbl[15] = '{4'b1110, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    // reset state
    clear_inputs();
    drive();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // directed table: contention, port-0 preemption, locking, write
    for (int p = 0; p < NP; p++) begin
      t_addr[p]  = IW'(16 * p + 1);
      t_tag[p]   = TW'(p + 100);
      t_wdata[p] = E'(p * 7 + 3);
      t_be[p]    = BW'(p + 1);
    end
    for (int i = 0; i < 17; i++) begin
      for (int p = 0; p < NP; p++) t_req[p] = tbl[i].rq[p] ? 8'h01 : 8'h00;
      t_lock = tbl[i].lk;
      t_we   = tbl[i].wr;
      settle_check();
`ifdef DCACHE_ARB_RR_EN
      chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].g_rr);
      chk($sformatf("tbl%0d_rvalid", i), rvalid_o, tbl[i].v_rr);
`else
      chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].g_fx);
      chk($sformatf("tbl%0d_rvalid", i), rvalid_o, tbl[i].v_fx);
`endif
      tick();
    end

    // single read: port 2, way 3 hits
    clear_inputs();
    t_req[2] = 8'hFF; t_addr[2] = 12'h040; t_tag[2] = 44'hABC;
    settle_check();
    chk("rd_gnt", gnt_o, 4'b0100);
    chk("rd_addr", ram_addr_o, 12'h040);
    tick();
    clear_inputs();
    t_rd[3] = {1'b1, 1'b0, 44'hABC, 128'h1234};
    t_rd[6] = {1'b0, 1'b1, 44'hABC, 128'h5678};
    settle_check();
    chk("rd_rvalid", rvalid_o, 4'b0100);
    chk("rd_hit", hit_way_o, 8'h08);
    chk("rd_multi", multi_hit_o, 1'b0);
    tick();

    // multi-hit: ways 0 and 5 match
    clear_inputs();
    t_req[1] = 8'h21; t_tag[1] = 44'h123;
    settle_check();
    tick();
    t_req[1] = '0;
    t_rd[0] = {1'b1, 1'b0, 44'h123, 128'hAA};
    t_rd[2] = {1'b1, 1'b0, 44'h124, 128'hBB};
    t_rd[4] = {1'b0, 1'b0, 44'h123, 128'hCC};
    t_rd[5] = {1'b1, 1'b1, 44'h123, 128'hDD};
    settle_check();
    chk("mh_hit", hit_way_o, 8'h21);
    chk("mh_multi", multi_hit_o, 1'b1);
    tick();

    // write from port 1: no response next cycle even with matching ways
    t_req[1] = 8'h04; t_we = 4'b0010; t_be[1] = 22'h2A5A5A; t_wdata[1] = E'(128'hFEED);
    settle_check();
    chk("wr_we", ram_we_o, 1'b1);
    chk("wr_be", ram_be_o, 22'h2A5A5A);
    tick();
    t_req[1] = '0; t_we = '0;
    settle_check();
    chk("wr_rvalid", rvalid_o, 4'b0000);
    chk("wr_hit", hit_way_o, 8'h00);
    tick();

    // reset in the middle of a port-3 lock
    clear_inputs();
    t_req[3] = 8'h01; t_lock = 4'b1000;
    settle_check();
    tick();
    t_req[1] = 8'h01;
    settle_check();
    chk("lk_gnt", gnt_o, 4'b1000);
    #2 rst = 1'b1;
    clear_inputs();
    t_rd[0] = {1'b1, 1'b0, 44'h0, 128'h0};
    drive();
    #1;
    model_reset();
    check_all_zero("midlock");
    @(posedge clk);
    #1 rst = 1'b0;
    t_req[1] = 8'h01; t_req[3] = 8'h01;
    settle_check();
    chk("postrst_gnt", gnt_o, 4'b0010);
    tick();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        t_req[p]   = ($urandom_range(0, 1) == 1) ? NW'($urandom) : '0;
        t_addr[p]  = IW'($urandom);
        t_tag[p]   = TW'(16 + $urandom_range(0, 2));
        t_wdata[p] = E'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        t_be[p]    = BW'($urandom);
      end
      for (int p = 0; p < NP; p++) begin
        t_lock[p] = ($urandom_range(0, 9) < 3);
        t_we[p]   = ($urandom_range(0, 3) == 0);
      end
      for (int w = 0; w < NW; w++)
        t_rd[w] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(16 + $urandom_range(0, 2)),
                   LW'({$urandom, $urandom, $urandom, $urandom})};
      settle_check();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
